// File: rtl/readback_pkg.sv
// Shared types for the frame RAM readback sequencer: sweep states and output buffer depth.
package readback_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, REARM} state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/readback_fifo2.sv
// Two-entry FIFO of {last, data} that absorbs the RAM read latency under backpressure.
module readback_fifo2
  import readback_pkg::*;
#(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [BUF_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign w_pop = i_pop && (r_occ != 2'd0);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

  // The upstream issue rule must guarantee room for every returning read.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    i_push |-> (r_occ < 2'(BUF_DEPTH)));

endmodule

// File: rtl/readback_sequencer.sv
// Sweeps the frame RAM once per rising start level and streams the words out over valid/ready.
module readback_sequencer
  import readback_pkg::*;
#(
  parameter int NUM_WORDS = 2048,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [1:0]        w_occ;
  logic [DATA_W:0]   w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_pending;

  assign w_valid   = (w_occ != 2'd0);
  assign w_pop     = w_valid && i_out_ready;
  // Words that will occupy the buffer next cycle if nothing new is issued now.
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_next = RUN;
      RUN: begin
        w_issue = (w_pending < 3'(BUF_DEPTH));
        if (w_issue && (r_addr == LAST_ADDR)) w_next = DRAIN;
      end
      DRAIN: if (!r_inflight && (w_occ == 2'd0)) w_next = DONE;
      DONE:  w_next = REARM;
      REARM: if (!i_start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_last_addr     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_addr == LAST_ADDR);
      if ((r_state == IDLE) && i_start) begin
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_last_addr <= r_addr;
      end
    end
  end

  readback_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_inflight),
    .i_push_data({r_inflight_last, i_rd_data}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_occ      (w_occ)
  );

  assign o_rd_en     = w_issue;
  assign o_rd_addr   = w_issue ? r_addr : r_last_addr;
  assign o_out_valid = w_valid;
  assign o_out_data  = w_valid ? w_head[DATA_W-1:0] : '0;
  assign o_out_last  = w_valid && w_head[DATA_W];
  assign o_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_readback_sequencer.sv
// Directed-plus-random bench for readback_sequencer; expectations come from a word-order/handshake model.
module tb_readback_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start8 = 1'b0, ready8 = 1'b1;
  logic        rdEn8, valid8, last8, busy8, done8;
  logic [10:0] rdAddr8;
  logic [23:0] rdData8 = '0, outData8;
  logic        start2 = 1'b0, ready2 = 1'b0;
  logic        rdEn2, valid2, last2, busy2, done2;
  logic [10:0] rdAddr2;
  logic [23:0] rdData2 = '0, outData2;

  logic [23:0] mem [0:7];

  int total = 0;
  int bad   = 0;

  int          rdCyc[$];
  logic [10:0] rdAddr[$];
  logic [23:0] gotData[$];
  logic        gotLast[$];
  int          gotCyc[$];
  int          doneCyc[$];
  int          overlapErr, stableErr, holdErr, outstandErr;

  readback_sequencer #(.NUM_WORDS(8), .ADDR_W(11), .DATA_W(24)) dut8 (
    .clk(clk), .reset(reset), .i_start(start8), .o_rd_en(rdEn8), .o_rd_addr(rdAddr8),
    .i_rd_data(rdData8), .o_out_data(outData8), .o_out_valid(valid8), .i_out_ready(ready8),
    .o_out_last(last8), .o_busy(busy8), .o_done(done8)
  );

  readback_sequencer #(.NUM_WORDS(2), .ADDR_W(11), .DATA_W(24)) dut2 (
    .clk(clk), .reset(reset), .i_start(start2), .o_rd_en(rdEn2), .o_rd_addr(rdAddr2),
    .i_rd_data(rdData2), .o_out_data(outData2), .o_out_valid(valid2), .i_out_ready(ready2),
    .o_out_last(last2), .o_busy(busy2), .o_done(done2)
  );

  // Synchronous RAM models: data appears the cycle after the read strobe.
  always @(posedge clk) if (rdEn8) rdData8 <= mem[rdAddr8[2:0]];
  always @(posedge clk) if (rdEn2) rdData2 <= mem[rdAddr2[2:0]];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      ready8 = 1'b1;
    end
  endtask

  // Cycle c of a sweep is t+c, where t is the edge that first samples start high.
  task automatic applyStimulus(input int readyMode, input int startLowAt, input int nCycles);
    int          issued = 0;
    int          popped = 0;
    logic        held = 1'b0;
    logic [23:0] heldData = '0;
    logic        heldLast = 1'b0;
    logic [10:0] lastIss = '0;
    rdCyc.delete(); rdAddr.delete(); gotData.delete(); gotLast.delete();
    gotCyc.delete(); doneCyc.delete();
    overlapErr = 0; stableErr = 0; holdErr = 0; outstandErr = 0;
    for (int c = 0; c < nCycles; c++) begin
      @(posedge clk); #1;
      start8 = (c == 0) || (startLowAt < 0) || (c < startLowAt);
      case (readyMode)
        0:       ready8 = 1'b1;
        1:       ready8 = ((c % 3) == 0);
        default: ready8 = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (held && !(valid8 && (outData8 === heldData) && (last8 === heldLast))) stableErr++;
      if (rdEn8) begin
        rdCyc.push_back(c);
        rdAddr.push_back(rdAddr8);
        lastIss = rdAddr8;
        issued++;
      end else if (issued > 0 && rdAddr8 !== lastIss) begin
        holdErr++;
      end
      if (valid8 && ready8) begin
        gotData.push_back(outData8);
        gotLast.push_back(last8);
        gotCyc.push_back(c);
        popped++;
      end
      if (issued - popped > 2) outstandErr++;
      held     = valid8 && !ready8;
      heldData = outData8;
      heldLast = last8;
      if (done8) doneCyc.push_back(c);
      if (done8 && busy8) overlapErr++;
    end
  endtask

  // Model: one sweep delivers mem[0..7] in order, last only on the final word,
  // reads issued for addresses 0..7 starting at t+1, and done two cycles after the final pop.
  task automatic verifySweep(input string name);
    int lastPop;
    checkOutput({name, ".nwords"}, gotData.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s.data%0d", name, i), gotData[i], mem[i]);
      checkOutput($sformatf("%s.last%0d", name, i), gotLast[i], (i == 7));
    end
    checkOutput({name, ".nreads"}, rdCyc.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("%s.addr%0d", name, i), rdAddr[i], i);
    checkOutput({name, ".firstRdCyc"}, rdCyc[0], 1);
    lastPop = (gotCyc.size() > 0) ? gotCyc[gotCyc.size()-1] : -100;
    checkOutput({name, ".ndone"}, doneCyc.size(), 1);
    checkOutput({name, ".doneCyc"}, doneCyc[0], lastPop + 2);
    checkOutput({name, ".doneBusy"}, overlapErr, 0);
    checkOutput({name, ".stable"}, stableErr, 0);
    checkOutput({name, ".addrHold"}, holdErr, 0);
    checkOutput({name, ".outstanding"}, outstandErr, 0);
  endtask

  initial begin
    int rdCnt2, vCnt;
    int rd2Cyc[$];
    logic [23:0] got2[$];
    logic got2Last[$];
    int got2Cyc[$];
    int done2Cyc[$];

    for (int i = 0; i < 8; i++) mem[i] = 24'h100 + 24'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.dut8", {rdEn8, rdAddr8, valid8, last8, outData8, busy8, done8}, 0);
    checkOutput("reset.dut2", {rdEn2, rdAddr2, valid2, last2, outData2, busy2, done2}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idleCycles(2);

    // Sweep with ready held high and start held high long past done
    $display("[TB] sweep: ready high, start held");
    applyStimulus(0, -1, 34);
    verifySweep("s1");
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s1.rdCyc%0d", i), rdCyc[i], i + 1);
      checkOutput($sformatf("s1.outCyc%0d", i), gotCyc[i], i + 3);
    end
    checkOutput("s1.doneAt12", doneCyc[0], 12);

    // Re-armed sweep with ready pattern 1,0,0 and random RAM contents
    $display("[TB] sweep: toggling ready");
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    idleCycles(3);
    applyStimulus(1, 12, 60);
    verifySweep("s2");

    $display("[TB] sweep: random ready");
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    idleCycles(3);
    applyStimulus(2, 40, 90);
    verifySweep("s3");

    $display("[TB] sweep: start dropped mid-run");
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    idleCycles(3);
    applyStimulus(0, 4, 25);
    verifySweep("s4");

    // Reset on the cycle that issues address 3
    $display("[TB] reset mid-sweep");
    idleCycles(3);
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      start8 = 1'b1;
      ready8 = 1'b1;
      #1;
      if (c == 4) begin
        checkOutput("rst.issue3", {rdEn8, rdAddr8}, {1'b1, 11'd3});
        reset = 1'b1;
      end
    end
    @(posedge clk); #1;
    reset  = 1'b0;
    start8 = 1'b0;
    #1;
    checkOutput("rst.outputs", {rdEn8, rdAddr8, valid8, last8, outData8, busy8, done8}, 0);
    vCnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (valid8 || rdEn8 || busy8 || done8) vCnt++;
    end
    checkOutput("rst.quiet", vCnt, 0);
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    applyStimulus(0, 14, 20);
    verifySweep("s5");

    // Two-word sweep with ready held low until t+10
    $display("[TB] two-word sweep with stalled consumer");
    rdCnt2 = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      start2 = (c < 16);
      ready2 = (c >= 10);
      #1;
      if (rdEn2) begin
        rdCnt2++;
        rd2Cyc.push_back(c);
      end
      if (valid2 && ready2) begin
        got2.push_back(outData2);
        got2Last.push_back(last2);
        got2Cyc.push_back(c);
      end
      if (done2) done2Cyc.push_back(c);
    end
    checkOutput("n2.nreads", rdCnt2, 2);
    checkOutput("n2.rdCyc0", rd2Cyc[0], 1);
    checkOutput("n2.rdCyc1", rd2Cyc[1], 2);
    checkOutput("n2.nwords", got2.size(), 2);
    checkOutput("n2.data0", got2[0], mem[0]);
    checkOutput("n2.data1", got2[1], mem[1]);
    checkOutput("n2.last0", got2Last[0], 0);
    checkOutput("n2.last1", got2Last[1], 1);
    checkOutput("n2.outCyc0", got2Cyc[0], 10);
    checkOutput("n2.outCyc1", got2Cyc[1], 11);
    checkOutput("n2.ndone", done2Cyc.size(), 1);
    checkOutput("n2.doneCyc", done2Cyc[0], 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/readback_sequencer.md
# readback_sequencer

Downstream consumer of the write-settle counter's `start` level. Once `start` is sampled high, sweeps the frame RAM read port from address 0 to NUM_WORDS-1 at up to one word per cycle. Streams each word out over a valid/ready interface, absorbing the RAM's one-cycle read latency in a 2-entry buffer so backpressure never drops data. On completion it pulses `done`, which the top level wires to the counter's `cleared` input. It then re-arms only after `start` falls.

## Interface
- NUM_WORDS, 2048: words per sweep, 2..2^ADDR_W
- ADDR_W, 11: RAM address width
- DATA_W, 24: RAM word width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  level from counter; high = memory written and settled
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address, valid with rd_en
- rd_data  in  DATA_W  RAM output, valid exactly one cycle after rd_en
- out_data  out  DATA_W  stream word
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_last  out  1  marks word from address NUM_WORDS-1
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of sweep

## Operation
- States:
  - IDLE: start=1 → RUN; addr←0.
  - RUN: issue reads; after issuing address NUM_WORDS-1 → DRAIN.
  - DRAIN: no issues; when inflight=0 and buffer empty → DONE.
  - DONE: done=1 for this single cycle → REARM.
  - REARM: wait for start=0 → IDLE.
- Issue rule, RUN only: rd_en = (occ + inflight − pop) < 2.
  - occ = buffer occupancy, 0..2.
  - inflight = registered rd_en of the previous cycle.
  - pop = out_valid && out_ready.
  - On issue, addr increments; addr width ADDR_W, no wrap needed since issuing stops at NUM_WORDS-1.
- Capture: in the cycle after rd_en, rd_data plus a last tag (issued addr == NUM_WORDS-1) are pushed into the buffer. The push is guaranteed to fit by the issue rule.
- Buffer: 2-entry FIFO.
  - out_valid = occ≠0.
  - out_data/out_last taken from the head.
  - Simultaneous push and pop keeps occ unchanged.
- start falling during RUN/DRAIN is ignored; the sweep always completes. There is no abort except reset.
- start still high in REARM does not retrigger. This prevents a double sweep before the counter sees `cleared`.
- Reset (any state, including mid-sweep):
  - state→IDLE; addr, inflight, and occ→0.
  - A rd_data returning the cycle after reset is discarded.
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.

## Timing
- start sampled high at edge t (IDLE) → RUN in cycle t+1.
  - First rd_en (addr 0) in cycle t+1.
  - rd_data in t+2; out_valid in t+3.
- With out_ready held high: one word per cycle, no bubbles.
  - NUM_WORDS words appear on cycles t+3 .. t+2+NUM_WORDS.
  - done in cycle t+4+NUM_WORDS. DRAIN is entered at t+1+NUM_WORDS, buffer empties after the last pop, then DONE.
- out_ready low: at most two words issued beyond the last pop. Issue stalls; out_data/out_valid are held stable until accepted.
- done and busy are never high together. done is high for exactly one cycle per sweep.
- rd_addr is held at its last issued value when rd_en=0.

## Structure
- Package readback_pkg:
  - typedef enum state_t {IDLE, RUN, DRAIN, DONE, REARM};
  - localparam BUF_DEPTH=2.
- One sub-module: readback_fifo2, the 2-entry FIFO of {last, data}.
  - Ports: push, push_data, pop, head, occ.
  - Push-while-full is illegal and asserted in simulation.
- Top: FSM, address counter, inflight register, issue logic.

## Test plan
- NUM_WORDS=8, RAM model returns data=addr+0x100, out_ready=1, start raised at t:
  - rd_en t+1..t+8 with addr 0..7.
  - out_data 0x100..0x107 on t+3..t+10; out_last only with 0x107.
  - done at t+12 only.
- Same sweep with out_ready toggling 1,0,0,1…:
  - All 8 words are delivered in order with none lost or duplicated.
  - occ never exceeds 2; out_data is stable whenever out_valid=1 and out_ready=0.
- start held high through DONE and 20 further cycles:
  - Exactly one done pulse; no new rd_en.
  - After start=0 then start=1, a second full sweep starts at addr 0.
- start dropped to 0 in cycle t+4 (mid-RUN): the sweep still completes all 8 words and the done pulse.
- reset asserted on the cycle rd_en issues addr 3:
  - Next cycle all outputs are at reset values; the returning rd_data is not emitted.
  - A subsequent start performs a clean sweep from 0.
- NUM_WORDS=2 with out_ready=0 until cycle t+10:
  - Exactly two rd_en, then a stall.
  - Both words are emitted after ready rises; out_last is on the second word, followed by done.
